// File: rtl/uart_cmd_decoder.sv
// UART byte-stream command decoder driving a register-file port.
// Define UART_CMD_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module uart_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  input  logic                  rx_d_vld,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_vld,
  input  logic                  tx_busy,
  output logic                  frame_err
);

  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_SEND
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_d_vld_q, tx_d_vld_d;
  logic                  err_q, err_d;
  logic                  acc;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    tx_p_data_d = tx_p_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_d_vld_d  = 1'b0;
    err_d       = 1'b0;
    acc         = 1'b0;
    unique case (state_q)
      S_IDLE: if (rx_d_vld) begin
        acc = 1'b1;
        if (rx_p_data == OP_WR)      state_d = S_WR_ADDR;
        else if (rx_p_data == OP_RD) state_d = S_RD_ADDR;
        else                         err_d   = 1'b1;
      end
      S_WR_ADDR: if (rx_d_vld) begin
        acc     = 1'b1;
        addr_d  = rx_p_data[ADDR_WIDTH-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (rx_d_vld) begin
        acc       = 1'b1;
        wr_data_d = rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = S_IDLE;
      end
      S_RD_ADDR: if (rx_d_vld) begin
        acc     = 1'b1;
        addr_d  = rx_p_data[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        state_d = S_RD_WAIT;
      end
      // Bytes arriving while a read is in flight are overruns.
      S_RD_WAIT: begin
        err_d = rx_d_vld;
        if (rd_data_vld) begin
          tx_p_data_d = rd_data;
          state_d     = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        err_d = rx_d_vld;
        if (!tx_busy) begin
          tx_d_vld_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    timed = state_q inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT};
    cnt_d = '0;
    if (timed && !acc && state_d == state_q) begin
      if (cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      tx_p_data_q <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_d_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      tx_p_data_q <= tx_p_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tx_d_vld_q  <= tx_d_vld_d;
      err_q       <= err_d;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign tx_p_data = tx_p_data_q;
  assign tx_d_vld  = tx_d_vld_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed timing steps
// followed by random frames checked against a frame-level model.
module tb_uart_cmd_decoder;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  localparam int WG = (TO > 16) ? 15 : 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_p_data = 8'h00;
  logic       rx_d_vld = 1'b0;
  logic       wr_en, rd_en, tx_d_vld, frame_err, tx_busy;
  logic [3:0] addr;
  logic [7:0] wr_data, tx_p_data;
  logic [7:0] rd_data = 8'h00;
  logic       rd_data_vld = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_p_data  (rx_p_data),
    .rx_d_vld   (rx_d_vld),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rd_data_vld(rd_data_vld),
    .tx_p_data  (tx_p_data),
    .tx_d_vld   (tx_d_vld),
    .tx_busy    (tx_busy),
    .frame_err  (frame_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed events
  logic [11:0] o_wr[$];
  logic [3:0]  o_rd[$];
  logic [7:0]  o_tx[$];
  int o_err = 0;
  int wr_cyc = -1, rd_cyc = -1, tx_cyc = -1, err_cyc = -1, vld_cyc = -1;
  logic [7:0] rf [16] = '{default: 8'h00};

  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        o_wr.push_back({addr, wr_data});
        rf[addr] = wr_data;
        wr_cyc = cyc;
      end
      if (rd_en) begin
        o_rd.push_back(addr);
        rd_cyc = cyc;
      end
      if (tx_d_vld) begin
        o_tx.push_back(tx_p_data);
        tx_cyc = cyc;
      end
      if (frame_err) begin
        o_err++;
        err_cyc = cyc;
      end
    end
  end

  // register-file responder
  int resp_dly = 0;
  logic [3:0] ra;
  always @(negedge clk) begin
    if (rst && rd_en) begin
      ra = addr;
      if (resp_dly >= 0) repeat (resp_dly) @(negedge clk);
      else repeat ($urandom_range(0, 4)) @(negedge clk);
      rd_data = rf[ra];
      rd_data_vld = 1'b1;
      vld_cyc = cyc;
      @(negedge clk);
      rd_data_vld = 1'b0;
    end
  end

  logic busy_force = 1'b0, busy_rand_en = 1'b0, busy_r = 1'b0;
  always @(negedge clk) busy_r <= ($urandom_range(0, 2) == 0);
  assign tx_busy = busy_rand_en ? busy_r : busy_force;

  // frame-level reference model
  logic [11:0] e_wr[$];
  logic [3:0]  e_rd[$];
  logic [7:0]  e_tx[$];
  int e_err = 0;
  logic [7:0] mrf [16] = '{default: 8'h00};

  int total = 0, bad = 0, scyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld = 1'b1;
    scyc = cyc;
    @(negedge clk);
    rx_d_vld = 1'b0;
  endtask

  task automatic m_wr(input logic [7:0] a, input logic [7:0] d, input int g);
    send(8'hAA); gap(g);
    send(a); gap(g);
    send(d);
    e_wr.push_back({a[3:0], d});
    mrf[a[3:0]] = d;
  endtask

  task automatic m_rd(input logic [7:0] a, input int g);
    send(8'hBB); gap(g);
    send(a);
    e_rd.push_back(a[3:0]);
    e_tx.push_back(mrf[a[3:0]]);
  endtask

  task automatic wait_tx();
    int n = 0;
    while (o_tx.size() < e_tx.size() && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_wait", 32'(n < 100), 32'd1);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_wr_n"}, o_wr.size(), e_wr.size());
    chk({tag, "_rd_n"}, o_rd.size(), e_rd.size());
    chk({tag, "_tx_n"}, o_tx.size(), e_tx.size());
    chk({tag, "_err_n"}, o_err, e_err);
    if (o_wr.size() > 0 && e_wr.size() > 0)
      chk({tag, "_wr"}, 32'(o_wr[$]), 32'(e_wr[$]));
    if (o_rd.size() > 0 && e_rd.size() > 0)
      chk({tag, "_rd"}, 32'(o_rd[$]), 32'(e_rd[$]));
    if (o_tx.size() > 0 && e_tx.size() > 0)
      chk({tag, "_tx"}, 32'(o_tx[$]), 32'(e_tx[$]));
  endtask

  initial begin
    int c, b, kind, g;
    logic [7:0] ra8, rd8;

    // reset state
    gap(3);
    chk("rst_outs", 32'({wr_en, rd_en, tx_d_vld, frame_err,
                        addr, wr_data, tx_p_data}), 32'd0);
    rst = 1'b1;
    gap(2);

    // spaced write
    m_wr(8'h03, 8'h5C, WG);
    c = scyc;
    gap(3);
    chk("wr_lat", wr_cyc, c + 1);
    chk_all("wr");

    // read, rd_data_vld 4 cycles after rd_en
    m_wr(8'h07, 8'hE1, 0);
    gap(2);
    resp_dly = 4;
    m_rd(8'h07, 0);
    c = scyc;
    wait_tx();
    chk("rd_lat", rd_cyc, c + 1);
    chk("vld_lat", vld_cyc, rd_cyc + 4);
    chk("tx_lat", tx_cyc, vld_cyc + 2);
    gap(5);
    chk_all("rd");

    // minimum turnaround
    resp_dly = 0;
    m_rd(8'h03, 0);
    c = scyc;
    wait_tx();
    chk("turn3", tx_cyc, c + 3);
    gap(3);
    chk_all("turn");

    // transmitter busy with an overrun byte
    busy_force = 1'b1;
    resp_dly = 1;
    m_rd(8'h07, 0);
    gap(4);
    send(8'hAA);
    e_err++;
    c = scyc;
    gap(14);
    chk("tx_held", o_tx.size(), e_tx.size() - 1);
    chk("ovr_lat", err_cyc, c + 1);
    busy_force = 1'b0;
    b = cyc;
    wait_tx();
    chk("busy_rel", tx_cyc, b + 1);
    gap(3);
    chk_all("busy");

    // unknown command then a normal write
    send(8'h3F);
    e_err++;
    c = scyc;
    gap(4);
    chk("junk_lat", err_cyc, c + 1);
    chk("junk_once", o_err, e_err);
    m_wr(8'h01, 8'hFF, 0);
    gap(3);
    chk_all("junk");

`ifdef UART_CMD_TIMEOUT_EN
    send(8'hAA);
    e_err++;
    c = scyc;
    gap(12);
    chk("to_lat", err_cyc, c + 9);
    chk("to_err", o_err, e_err);
    m_wr(8'h02, 8'h11, 0);
    gap(3);
    chk_all("to");
`endif

    // reset between command and address
    send(8'hAA);
    gap(1);
    rst = 1'b0;
    #1;
    chk("rst_mid", 32'({wr_en, rd_en, tx_d_vld, frame_err,
                       addr, wr_data, tx_p_data}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    gap(1);
    send(8'h02);
    send(8'h11);
    e_err += 2;
    gap(3);
    chk_all("rstmid");

    // random frames
    busy_rand_en = 1'b1;
    resp_dly = -1;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      g = $urandom_range(0, 3);
      ra8 = 8'($urandom);
      rd8 = 8'($urandom);
      if (kind == 0) begin
        m_wr(ra8, rd8, g);
      end else if (kind == 1) begin
        m_rd(ra8, g);
        wait_tx();
      end else begin
        while (rd8 == 8'hAA || rd8 == 8'hBB) rd8 = 8'($urandom);
        send(rd8);
        e_err++;
      end
      gap(3);
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-level command decoder directly downstream of the UART receiver and upstream of the UART transmitter. Consumes received bytes (`rx_p_data`/`rx_d_vld`), parses write and read frames, and drives a register-file write/read port. Read results are returned as single bytes to the transmitter's parallel input. Sits in the UART RX clock domain's system-control path.

## Interface
- `DATA_WIDTH`, 8: byte width of RX/TX data and register data.
- `ADDR_WIDTH`, 4: register address width; taken from the low bits of the address byte.
- `TIMEOUT_CYCLES`, 1024: number of idle clock cycles allowed mid-frame (≥2).
- `clk`  in  1  block clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_p_data`  in  DATA_WIDTH  received byte.
- `rx_d_vld`  in  1  one-cycle strobe; `rx_p_data` valid.
- `wr_en`  out  1  one-cycle register write strobe.
- `rd_en`  out  1  one-cycle register read strobe.
- `addr`  out  ADDR_WIDTH  register address for `wr_en`/`rd_en`.
- `wr_data`  out  DATA_WIDTH  write data.
- `rd_data`  in  DATA_WIDTH  read data.
- `rd_data_vld`  in  1  `rd_data` valid strobe.
- `tx_p_data`  out  DATA_WIDTH  byte to transmitter.
- `tx_d_vld`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy.
- `frame_err`  out  1  one-cycle pulse: unknown command, timeout, or overrun.

## Operation
- Opcodes: `0xAA` = write frame (CMD, ADDR, DATA); `0xBB` = read frame (CMD, ADDR).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE: byte `0xAA` -> WR_ADDR; `0xBB` -> RD_ADDR; any other byte -> stay IDLE, pulse `frame_err`.
- WR_ADDR: byte -> latch `addr` = byte[ADDR_WIDTH-1:0], -> WR_DATA.
- WR_DATA: byte -> `wr_data` = byte, `wr_en` pulse, -> IDLE.
- RD_ADDR: byte -> latch `addr`, `rd_en` pulse, -> RD_WAIT.
- RD_WAIT: `rd_data_vld` -> capture `rd_data` into `tx_p_data`, -> TX_SEND.
- TX_SEND: when `tx_busy`=0, `tx_d_vld` pulse, -> IDLE; otherwise hold.
- `rx_d_vld` in RD_WAIT or TX_SEND: byte dropped, `frame_err` pulse (overrun); state unchanged.
- `rd_data_vld` outside RD_WAIT: ignored.
- `addr`, `wr_data`, `tx_p_data` hold their last values until overwritten.

## Timing
- All outputs registered. Reset value of every output: 0; state = IDLE; timeout counter = 0.
- Byte strobed in cycle N -> state/outputs update at the edge ending N; `wr_en`/`rd_en`/`frame_err` high in cycle N+1 only.
- `addr` and `wr_data` are stable in the `wr_en` cycle; `addr` is stable in the `rd_en` cycle.
- RD_WAIT samples `rd_data_vld` from the `rd_en` cycle onward. `rd_data_vld` in cycle M -> state is TX_SEND in M+1.
- TX_SEND entered in cycle K with `tx_busy`=0 in cycle K -> `tx_d_vld`=1 in K+1, state IDLE in K+1. `tx_p_data` is stable from K onward.
- Minimum read turnaround is 3 cycles, from the address strobe to `tx_d_vld`, when `rd_data_vld` is returned in the `rd_en` cycle.
- Back-to-back frames: `rx_d_vld` in consecutive cycles is accepted in every parsing state.
- Reset asserted mid-frame: immediate return to IDLE; all outputs 0 asynchronously; partial frame discarded.
- `frame_err` due to an overrun and a completing event in the same cycle: both outputs fire. At most one `frame_err` pulse is generated per cycle.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on every state change and every accepted byte.
  - The counter increments each cycle in WR_ADDR, WR_DATA, RD_ADDR, and RD_WAIT.
  - After TIMEOUT_CYCLES consecutive cycles without progress -> state IDLE and a `frame_err` pulse in the following cycle.
  - The counter saturates and never wraps.
- `UART_CMD_TIMEOUT_EN` undefined: no counter is built; the FSM waits indefinitely in every state.

## Test plan
- Bytes `AA`,`03`,`5C`, one per 16 cycles -> one `wr_en` pulse with `addr`=3 and `wr_data`=0x5C, one cycle after the `5C` strobe; no `frame_err`.
- Bytes `BB`,`07`; `rd_data`=0xE1 with `rd_data_vld` 4 cycles after `rd_en`; `tx_busy`=0 -> `rd_en` with `addr`=7, then a single `tx_d_vld` with `tx_p_data`=0xE1 exactly 2 cycles after `rd_data_vld`.
- Read as above with `tx_busy`=1 for 20 cycles -> `tx_d_vld` withheld; it fires one cycle after `tx_busy` falls. A byte `AA` arriving while waiting -> `frame_err` pulse and state stays TX_SEND.
- Byte `3F` in IDLE -> `frame_err` for exactly one cycle; a following `AA`,`01`,`FF` -> normal write to `addr`=1.
- With `UART_CMD_TIMEOUT_EN` and TIMEOUT_CYCLES=8: send `AA` then nothing -> `frame_err` 9 cycles after the strobe cycle, state IDLE. A subsequent `AA`,`02`,`11` completes normally.
- Assert `rst` low for 1 cycle between `AA` and the address byte -> all outputs 0. The following `02`,`11` bytes produce two `frame_err` pulses and no `wr_en`.
